// File: rtl/multiexp_feeder_if.sv
// Valid/ready stream bundle shared by the multiexp feeder and core.
interface if_axi_stream #(
  parameter int DAT_BITS = 8,
  parameter int CTL_BITS = 8
);
  logic                val;
  logic                rdy;
  logic                sop;
  logic                eop;
  logic                err;
  logic [CTL_BITS-1:0] ctl;
  logic [DAT_BITS-1:0] dat;

  modport source (output val, sop, eop, err, ctl, dat, input rdy);
  modport sink   (input val, sop, eop, err, ctl, dat, output rdy);
endinterface

// File: rtl/multiexp_feeder.sv
// Buffers one batch of {point, scalar} pairs, replays it KEY_BITS times to the
// multiexp core, then forwards the core's result. MULTIEXP_FEEDER_PERF_EN adds o_cycles.
module multiexp_feeder #(
  parameter int DAT_BITS = 256,
  parameter int PNT_BITS = 768,
  parameter int NUM_IN   = 4,
  parameter int KEY_BITS = 256,
  parameter int CTL_BITS = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  if_axi_stream.sink   i_load_if,
  if_axi_stream.source o_pnt_scl_if,
  if_axi_stream.sink   i_pnt_if,
  if_axi_stream.source o_res_if,
  output logic         o_busy,
  output logic         o_err
`ifdef MULTIEXP_FEEDER_PERF_EN
  ,
  output logic [31:0]  o_cycles
`endif
);

  localparam int BEAT_BITS = PNT_BITS + DAT_BITS;
  localparam int IDX_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int RND_W     = (KEY_BITS > 1) ? $clog2(KEY_BITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_IN - 1);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(KEY_BITS - 1);

  typedef enum logic [1:0] {LOAD, STREAM, WAIT_RES, OUT} state_t;

  state_t               state, state_nxt;
  logic [IDX_W-1:0]     idx, idx_nxt;
  logic [RND_W-1:0]     rnd, rnd_nxt;
  logic                 alive;
  logic                 err_nxt;
  logic                 buf_we;
  logic [BEAT_BITS-1:0] beat_buf [NUM_IN];
  logic [PNT_BITS-1:0]  res_q;

  logic load_hs, pnt_hs, res_in_hs, res_out_hs;
  assign load_hs    = i_load_if.val & i_load_if.rdy;
  assign pnt_hs     = o_pnt_scl_if.val & o_pnt_scl_if.rdy;
  assign res_in_hs  = i_pnt_if.val & i_pnt_if.rdy;
  assign res_out_hs = o_res_if.val & o_res_if.rdy;

  // alive keeps load rdy low while reset is held and for the deassertion cycle
  assign i_load_if.rdy = alive && (state == LOAD);

  assign o_pnt_scl_if.val = (state == STREAM);
  assign o_pnt_scl_if.sop = (state == STREAM);
  assign o_pnt_scl_if.eop = (state == STREAM);
  assign o_pnt_scl_if.err = 1'b0;
  assign o_pnt_scl_if.ctl = CTL_BITS'(idx);
  assign o_pnt_scl_if.dat = beat_buf[idx];

  assign i_pnt_if.rdy = (state == WAIT_RES);

  assign o_res_if.val = (state == OUT);
  assign o_res_if.sop = (state == OUT);
  assign o_res_if.eop = (state == OUT);
  assign o_res_if.err = 1'b0;
  assign o_res_if.ctl = '0;
  assign o_res_if.dat = res_q;

  assign o_busy = (state != LOAD);

  logic unused_sigs;
  assign unused_sigs = ^{i_load_if.sop, i_load_if.err, i_load_if.ctl,
                         i_pnt_if.sop, i_pnt_if.eop, i_pnt_if.err, i_pnt_if.ctl};

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    rnd_nxt   = rnd;
    err_nxt   = 1'b0;
    buf_we    = 1'b0;
    case (state)
      LOAD: begin
        if (load_hs) begin
          // early eop marks a short batch: drop the beat and restart the load
          if (i_load_if.eop && (idx != IDX_LAST)) begin
            err_nxt = 1'b1;
            idx_nxt = '0;
          end else begin
            buf_we = 1'b1;
            if (idx == IDX_LAST) begin
              idx_nxt   = '0;
              rnd_nxt   = '0;
              state_nxt = STREAM;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end
        end
      end
      STREAM: begin
        if (pnt_hs) begin
          if (idx == IDX_LAST) begin
            idx_nxt = '0;
            rnd_nxt = rnd + 1'b1;
            if (rnd == RND_LAST) begin
              rnd_nxt   = '0;
              state_nxt = WAIT_RES;
            end
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      WAIT_RES: if (res_in_hs) state_nxt = OUT;
      OUT:      if (res_out_hs) state_nxt = LOAD;
      default:  state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= LOAD;
      idx   <= '0;
      rnd   <= '0;
      alive <= 1'b0;
      o_err <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      rnd   <= rnd_nxt;
      alive <= 1'b1;
      o_err <= err_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (buf_we) beat_buf[idx] <= i_load_if.dat;
    if (res_in_hs) res_q <= i_pnt_if.dat;
  end

`ifdef MULTIEXP_FEEDER_PERF_EN
  logic [31:0] cyc_cnt;
  logic [31:0] cyc_sat;
  logic        counting;
  logic        first_beat;
  assign first_beat = pnt_hs && (idx == '0) && (rnd == '0);
  assign cyc_sat    = (cyc_cnt == '1) ? cyc_cnt : cyc_cnt + 32'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cyc_cnt  <= '0;
      counting <= 1'b0;
      o_cycles <= '0;
    end else if (first_beat) begin
      cyc_cnt  <= '0;
      counting <= 1'b1;
    end else if (counting) begin
      cyc_cnt <= cyc_sat;
      if (res_in_hs) begin
        counting <= 1'b0;
        o_cycles <= cyc_sat;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multiexp_feeder.sv
// Directed bench for multiexp_feeder with default parameters (4 pairs x 256 rounds).
module tb_multiexp_feeder;

  localparam int TOT = 1024;

  logic i_clk = 1'b0;
  logic i_rst_n;
  logic o_busy, o_err;
`ifdef MULTIEXP_FEEDER_PERF_EN
  logic [31:0] cycles;
`endif

  int total = 0;
  int bad   = 0;
  logic [1023:0] exp_buf [4];

  if_axi_stream #(.DAT_BITS(1024), .CTL_BITS(8)) load_if ();
  if_axi_stream #(.DAT_BITS(1024), .CTL_BITS(8)) pnt_scl_if ();
  if_axi_stream #(.DAT_BITS(768),  .CTL_BITS(8)) pnt_if ();
  if_axi_stream #(.DAT_BITS(768),  .CTL_BITS(8)) res_if ();

  multiexp_feeder #(.DAT_BITS(256), .PNT_BITS(768), .NUM_IN(4), .KEY_BITS(256), .CTL_BITS(8)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_load_if    (load_if),
    .o_pnt_scl_if (pnt_scl_if),
    .i_pnt_if     (pnt_if),
    .o_res_if     (res_if),
    .o_busy       (o_busy),
    .o_err        (o_err)
`ifdef MULTIEXP_FEEDER_PERF_EN
    ,
    .o_cycles     (cycles)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [1039:0] obs, input logic [1039:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [1023:0] pair(input int b, input int k);
    logic [31:0] w;
    w = 32'hA5A50000 + 32'(b * 256 + k);
    return {{24{w}}, 256'(b * 16 + k + 1)};
  endfunction

  function automatic logic [767:0] res_val(input int b);
    logic [31:0] w;
    w = 32'hC0DE0000 + 32'(b);
    return {24{w}};
  endfunction

  // Load beats one per cycle; bad_at >= 0 raises eop early on that beat.
  task automatic load_batch(input int b, input int bad_at);
    for (int k = 0; k < 4; k++) begin
      chk("load_rdy", load_if.rdy, 1);
      load_if.val = 1'b1;
      load_if.dat = pair(b, k);
      load_if.eop = (k == 3) || (k == bad_at);
      if (bad_at < 0) exp_buf[k] = pair(b, k);
      @(negedge i_clk);
      if (k == bad_at) break;
    end
    load_if.val = 1'b0;
    load_if.eop = 1'b0;
  endtask

  task automatic stream(input bit bp, input int stop);
    int n;
    int cyc;
    logic r;
    n = 0;
    cyc = 0;
    while (n < stop && cyc < 5000) begin
      chk("str_val", pnt_scl_if.val, 1);
      chk("beat", {6'b0, pnt_scl_if.sop, pnt_scl_if.eop, pnt_scl_if.ctl, pnt_scl_if.dat},
                  {6'b0, 2'b11, 8'(n % 4), exp_buf[n % 4]});
      chk("pnt_rdy_str", pnt_if.rdy, 0);
      r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      pnt_scl_if.rdy = r;
      if (r) n++;
      @(negedge i_clk);
      cyc++;
    end
    chk("beat_count", n, stop);
    if (stop == TOT) begin
      chk("str_val_drop", pnt_scl_if.val, 0);
      chk("busy_wait", o_busy, 1);
    end
    pnt_scl_if.rdy = 1'b0;
  endtask

  task automatic result_phase(input int wait_n, input logic [767:0] r, input bit early);
    chk("pnt_rdy_wait", pnt_if.rdy, 1);
    if (!early) begin
      repeat (wait_n) @(negedge i_clk);
      pnt_if.val = 1'b1;
      pnt_if.dat = r;
    end
    @(negedge i_clk);
    pnt_if.val = 1'b0;
    chk("res_beat", {res_if.val, res_if.sop, res_if.eop, res_if.ctl, res_if.dat},
                    {3'b111, 8'h00, r});
    chk("pnt_rdy_out", pnt_if.rdy, 0);
    repeat (2) begin
      @(negedge i_clk);
      chk("res_hold", {res_if.val, res_if.dat}, {1'b1, r});
    end
    res_if.rdy = 1'b1;
    @(negedge i_clk);
    res_if.rdy = 1'b0;
    chk("res_val_drop", res_if.val, 0);
    chk("busy_idle", o_busy, 0);
    chk("load_rdy_again", load_if.rdy, 1);
  endtask

  initial begin
    i_rst_n = 1'b0;
    load_if.val = 1'b0; load_if.sop = 1'b0; load_if.eop = 1'b0; load_if.err = 1'b0;
    load_if.ctl = '0;   load_if.dat = '0;
    pnt_if.val = 1'b0;  pnt_if.sop = 1'b0;  pnt_if.eop = 1'b0;  pnt_if.err = 1'b0;
    pnt_if.ctl = '0;    pnt_if.dat = '0;
    pnt_scl_if.rdy = 1'b0;
    res_if.rdy = 1'b0;

    // reset state
    @(negedge i_clk);
    chk("rst_load_rdy", load_if.rdy, 0);
    chk("rst_vals", {pnt_scl_if.val, res_if.val, pnt_if.rdy, o_busy, o_err}, 0);
`ifdef MULTIEXP_FEEDER_PERF_EN
    chk("rst_cycles", cycles, 0);
`endif
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // nominal, result 10 cycles after the last beat
    load_batch(0, -1);
    stream(1'b0, TOT);
    result_phase(9, res_val(0), 1'b0);
`ifdef MULTIEXP_FEEDER_PERF_EN
    chk("cycles_1033", cycles, 1033);
`endif

    // random back-pressure
    load_batch(1, -1);
    stream(1'b1, TOT);
    result_phase(0, res_val(1), 1'b0);

    // malformed load then a good one, with result presented early
    load_batch(2, 1);
    chk("err_pulse", o_err, 1);
    chk("err_no_stream", {pnt_scl_if.val, o_busy}, 0);
    @(negedge i_clk);
    chk("err_clear", o_err, 0);
    load_batch(3, -1);
    pnt_if.val = 1'b1;
    pnt_if.dat = res_val(3);
    stream(1'b0, TOT);
    result_phase(0, res_val(3), 1'b1);
`ifdef MULTIEXP_FEEDER_PERF_EN
    chk("cycles_1024", cycles, 1024);
`endif

    // reset mid-stream, then a fresh batch
    load_batch(4, -1);
    stream(1'b0, 500);
    i_rst_n = 1'b0;
    #1;
    chk("midrst_vals", {pnt_scl_if.val, res_if.val, pnt_if.rdy, o_busy, load_if.rdy}, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("midrst_load_rdy", load_if.rdy, 1);
    load_batch(5, -1);
    stream(1'b1, TOT);
    result_phase(3, res_val(5), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
